// File: rtl/spram_256ka_pkg.sv
// rtl/spram_256ka_pkg.sv - shared geometry constants for the 256 Kbit single-port SRAM
package spram_256ka_pkg;

  localparam int SPRAM_ADDR_W = 14;
  localparam int SPRAM_DATA_W = 16;
  localparam int SPRAM_DEPTH  = 1 << SPRAM_ADDR_W;
  localparam int SPRAM_MASK_W = SPRAM_DATA_W / 4;

endpackage

// File: rtl/spram_256ka_if.sv
// rtl/spram_256ka_if.sv - vendor-named SRAM port bundle with master/slave views
interface spram_256ka_if;
  import spram_256ka_pkg::*;

  logic [SPRAM_ADDR_W-1:0] ADDRESS;
  logic [SPRAM_DATA_W-1:0] DATAIN;
  logic [SPRAM_MASK_W-1:0] MASKWREN;
  logic                    WREN;
  logic                    CHIPSELECT;
  logic                    STANDBY;
  logic                    SLEEP;
  logic                    POWEROFF;
  logic [SPRAM_DATA_W-1:0] DATAOUT;

  modport master (
    output ADDRESS, DATAIN, MASKWREN, WREN, CHIPSELECT, STANDBY, SLEEP, POWEROFF,
    input  DATAOUT
  );

  modport slave (
    input  ADDRESS, DATAIN, MASKWREN, WREN, CHIPSELECT, STANDBY, SLEEP, POWEROFF,
    output DATAOUT
  );

endinterface

// File: rtl/spram_256ka_nibble_lane.sv
// rtl/spram_256ka_nibble_lane.sv - one 4-bit lane of the array with its registered read nibble
module spram_256ka_nibble_lane
  import spram_256ka_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SPRAM_ADDR_W-1:0] addr,
  input  logic [3:0]              din,
  input  logic                    we,
  input  logic                    rd,
  input  logic                    clr,
  output logic [3:0]              dout
);

  // Storage is deliberately left without reset so the tool can map it to block RAM.
  logic [3:0] mem [SPRAM_DEPTH];

  // Lane write: caller has already folded reset, enables and this lane's mask bit into we.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
  end

  // Read nibble register: reset and power gating clear it, a read loads it, otherwise it holds.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      dout <= 4'h0;
    end else if (rd) begin
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/spram_256ka.sv
// rtl/spram_256ka.sv - behavioural drop-in for the iCE40UP 16K x 16 single-port SRAM
module spram_256ka
  import spram_256ka_pkg::*;
(
  input  logic          CLOCK,
  input  logic          RESET,
  spram_256ka_if.slave  bus
);

  logic                    power_gated;
  logic                    en;
  logic                    rd;
  logic [SPRAM_MASK_W-1:0] we;
  logic [3:0]              lane_q [SPRAM_MASK_W];

  // Access qualification: power gating outranks standby/chip-select, and reset blocks any array write.
  always_comb begin
    power_gated = bus.SLEEP | ~bus.POWEROFF;
    en          = bus.CHIPSELECT & ~bus.STANDBY & ~power_gated;
    rd          = en & ~bus.WREN;
    we          = '0;
    for (int i = 0; i < SPRAM_MASK_W; i++) begin
      we[i] = ~RESET & en & bus.WREN & bus.MASKWREN[i];
    end
  end

  // One independent lane per nibble so the write mask maps onto separate RAM slices.
  for (genvar g = 0; g < SPRAM_MASK_W; g++) begin : g_lane
    spram_256ka_nibble_lane u_lane (
      .clk  (CLOCK),
      .rst  (RESET),
      .addr (bus.ADDRESS),
      .din  (bus.DATAIN[4*g +: 4]),
      .we   (we[g]),
      .rd   (rd),
      .clr  (power_gated),
      .dout (lane_q[g])
    );
  end

  // Reassemble the registered lane outputs; no input reaches DATAOUT without passing a flop.
  always_comb begin
    bus.DATAOUT = '0;
    for (int i = 0; i < SPRAM_MASK_W; i++) begin
      bus.DATAOUT[4*i +: 4] = lane_q[i];
    end
  end

endmodule

// File: tb/tb_spram_256ka.sv
// tb/tb_spram_256ka.sv - self-checking bench for spram_256ka
module tb_spram_256ka;

  typedef struct {
    logic        rst;
    logic [13:0] addr;
    logic [15:0] din;
    logic [3:0]  mask;
    logic        wren;
    logic        cs;
    logic        stb;
    logic        slp;
    logic        pwr;
    logic [15:0] exp;
    string       name;
  } vec_t;

  typedef struct {
    logic [15:0] exp;
    string       name;
  } sb_t;

  logic clk = 1'b0;
  logic rst;

  spram_256ka_if bus ();

  spram_256ka dut (
    .CLOCK (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  sb_t         sb [$];
  vec_t        vecs [32];
  logic [15:0] mdl_mem [16384];
  logic [15:0] mdl_q;

  function automatic vec_t mk(input logic r, input logic [13:0] a, input logic [15:0] d,
                              input logic [3:0] m, input logic w, input logic c,
                              input logic s, input logic sl, input logic p,
                              input logic [15:0] e, input string n);
    vec_t v;
    v.rst = r; v.addr = a; v.din = d; v.mask = m; v.wren = w;
    v.cs = c; v.stb = s; v.slp = sl; v.pwr = p; v.exp = e; v.name = n;
    return v;
  endfunction

  task automatic drive(input vec_t v, output logic [15:0] pred);
    rst            = v.rst;
    bus.ADDRESS    = v.addr;
    bus.DATAIN     = v.din;
    bus.MASKWREN   = v.mask;
    bus.WREN       = v.wren;
    bus.CHIPSELECT = v.cs;
    bus.STANDBY    = v.stb;
    bus.SLEEP      = v.slp;
    bus.POWEROFF   = v.pwr;
    if (v.rst) begin
      mdl_q = 16'h0;
    end else if (v.slp || !v.pwr) begin
      mdl_q = 16'h0;
    end else if (v.cs && !v.stb) begin
      if (v.wren) begin
        for (int n = 0; n < 4; n++) begin
          if (v.mask[n]) mdl_mem[v.addr][4*n +: 4] = v.din[4*n +: 4];
        end
      end else begin
        mdl_q = mdl_mem[v.addr];
      end
    end
    pred = mdl_q;
  endtask

  task automatic check_one();
    sb_t e;
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty: got DATAOUT=%h with no expectation queued", bus.DATAOUT);
    end else begin
      e = sb.pop_front();
      if (bus.DATAOUT !== e.exp) begin
        failures++;
        $display("FAIL %s: DATAOUT=%h expected=%h", e.name, bus.DATAOUT, e.exp);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    logic [15:0] pred;
    logic [13:0] addr_pool [4];
    vec_t v;

    addr_pool[0] = 14'h0000; addr_pool[1] = 14'h0010;
    addr_pool[2] = 14'h3FFF; addr_pool[3] = 14'h02A5;
    for (int i = 0; i < 16384; i++) mdl_mem[i] = 16'h0;
    mdl_q = 16'h0;

    //              rst addr     din      mask  wr cs stb slp pwr exp      name
    vecs[0]  = mk(1, 14'h0000, 16'h0000, 4'hF, 0, 1, 0, 0, 1, 16'h0000, "reset_state");
    vecs[1]  = mk(0, 14'h0010, 16'hBEEF, 4'hF, 1, 1, 0, 0, 1, 16'h0000, "write_holds_out");
    vecs[2]  = mk(0, 14'h0010, 16'h0000, 4'h0, 0, 1, 0, 0, 1, 16'hBEEF, "full_read");
    vecs[3]  = mk(1, 14'h0010, 16'h0000, 4'h0, 0, 1, 0, 0, 1, 16'h0000, "reset_clears_out");
    vecs[4]  = mk(0, 14'h0010, 16'h0000, 4'h0, 0, 1, 0, 0, 1, 16'hBEEF, "reset_keeps_array");
    vecs[5]  = mk(0, 14'h0010, 16'h1234, 4'h5, 1, 1, 0, 0, 1, 16'hBEEF, "masked_write_hold");
    vecs[6]  = mk(0, 14'h0010, 16'h0000, 4'h0, 0, 1, 0, 0, 1, 16'hB2E4, "masked_read");
    vecs[7]  = mk(0, 14'h0010, 16'hBEEF, 4'hF, 1, 1, 0, 0, 1, 16'hB2E4, "restore_write");
    vecs[8]  = mk(0, 14'h0010, 16'h1234, 4'h0, 1, 1, 0, 0, 1, 16'hB2E4, "zero_mask_write");
    vecs[9]  = mk(0, 14'h0010, 16'h0000, 4'h0, 0, 1, 0, 0, 1, 16'hBEEF, "zero_mask_read");
    vecs[10] = mk(0, 14'h3FFF, 16'hAAAA, 4'hF, 1, 0, 0, 0, 1, 16'hBEEF, "cs_off_hold");
    vecs[11] = mk(0, 14'h3FFF, 16'h0000, 4'h0, 0, 1, 0, 0, 1, 16'h0000, "cs_off_no_write");
    vecs[12] = mk(0, 14'h0010, 16'h0000, 4'h0, 0, 1, 0, 0, 1, 16'hBEEF, "reload_beef");
    vecs[13] = mk(0, 14'h3FFF, 16'hAAAA, 4'hF, 1, 1, 1, 0, 1, 16'hBEEF, "standby_write_hold");
    vecs[14] = mk(0, 14'h3FFF, 16'h0000, 4'h0, 0, 1, 0, 0, 1, 16'h0000, "standby_no_write");
    vecs[15] = mk(0, 14'h0010, 16'h0000, 4'h0, 0, 1, 1, 0, 1, 16'h0000, "standby_read_hold");
    vecs[16] = mk(0, 14'h0010, 16'h0000, 4'h0, 0, 1, 0, 0, 1, 16'hBEEF, "read_before_sleep");
    vecs[17] = mk(0, 14'h0010, 16'h0000, 4'h0, 0, 1, 0, 1, 1, 16'h0000, "sleep_clears_out");
    vecs[18] = mk(0, 14'h0010, 16'h0000, 4'h0, 0, 1, 0, 0, 1, 16'hBEEF, "sleep_retains");
    vecs[19] = mk(0, 14'h0010, 16'h0000, 4'hF, 1, 1, 0, 0, 0, 16'h0000, "poweroff_clears_out");
    vecs[20] = mk(0, 14'h0010, 16'h0000, 4'h0, 0, 1, 0, 0, 1, 16'hBEEF, "poweroff_retains");
    vecs[21] = mk(0, 14'h0010, 16'h0000, 4'h0, 0, 0, 1, 1, 1, 16'h0000, "gating_over_standby");
    vecs[22] = mk(0, 14'h0000, 16'h0001, 4'hF, 1, 1, 0, 0, 1, 16'h0000, "b2b_write");
    vecs[23] = mk(0, 14'h0000, 16'h0000, 4'h0, 0, 1, 0, 0, 1, 16'h0001, "b2b_read_new");
    vecs[24] = mk(0, 14'h3FFF, 16'h0000, 4'h0, 0, 1, 0, 0, 1, 16'h0000, "interleave_top0");
    vecs[25] = mk(0, 14'h0000, 16'h0000, 4'h0, 0, 1, 0, 0, 1, 16'h0001, "interleave_bot0");
    vecs[26] = mk(0, 14'h3FFF, 16'h0000, 4'h0, 0, 1, 0, 0, 1, 16'h0000, "interleave_top1");
    vecs[27] = mk(0, 14'h3FFF, 16'h5A5A, 4'hF, 1, 1, 0, 0, 1, 16'h0000, "top_write");
    vecs[28] = mk(0, 14'h0000, 16'h0000, 4'h0, 0, 1, 0, 0, 1, 16'h0001, "interleave_bot1");
    vecs[29] = mk(0, 14'h3FFF, 16'h0000, 4'h0, 0, 1, 0, 0, 1, 16'h5A5A, "interleave_top2");
    vecs[30] = mk(1, 14'h0000, 16'hFFFF, 4'hF, 1, 1, 0, 0, 1, 16'h0000, "reset_blocks_write");
    vecs[31] = mk(0, 14'h0000, 16'h0000, 4'h0, 0, 1, 0, 0, 1, 16'h0001, "reset_write_blocked");

    for (int i = 0; i < 32; i++) begin
      drive(vecs[i], pred);
      sb.push_back('{vecs[i].exp, vecs[i].name});
      check_one();
    end

    // Random traffic over a few hot addresses, predicted by the bench model.
    for (int i = 0; i < 400; i++) begin
      v.rst  = ($urandom_range(15) == 0);
      v.addr = addr_pool[$urandom_range(3)];
      v.din  = 16'($urandom);
      v.mask = 4'($urandom);
      v.wren = 1'($urandom);
      v.cs   = ($urandom_range(7) != 0);
      v.stb  = ($urandom_range(7) == 0);
      v.slp  = ($urandom_range(7) == 0);
      v.pwr  = ($urandom_range(7) != 0);
      v.exp  = 16'h0;
      v.name = "random";
      drive(v, pred);
      sb.push_back('{pred, $sformatf("random_%0d", i)});
      check_one();
    end

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
